// File: rtl/register_pkg.sv
// Shared register-file constants and the write-back entry layout used by
// the write-port merger and its load-result FIFO.
package register_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: holds {rd, data} pairs until the write port is free and
// exports per-entry valid/rd so the issue stage can see pending destinations.
module wb_fifo
    import register_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic [REG_ADDR_WIDTH-1:0]            push_rd,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic                                 pop,
    output logic [REG_ADDR_WIDTH-1:0]            head_rd,
    output logic [DATA_WIDTH-1:0]                head_data,
    output logic                                 full,
    output logic                                 empty,
    output logic [CW-1:0]                        count,
    output logic [DEPTH-1:0]                     valid_vec,
    output logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_vec
);

    logic [DATA_WIDTH-1:0]                data_mem [DEPTH];
    logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_mem;
    logic [DEPTH-1:0]                     valid_q;
    logic [PW-1:0]                        wr_ptr;
    logic [PW-1:0]                        rd_ptr;
    logic                                 do_push;
    logic                                 do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            rd_mem[wr_ptr]   <= push_rd;
        end
    end

    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign valid_vec = valid_q;
    assign rd_vec    = rd_mem;

endmodule

// File: rtl/register_writeback.sv
// Register-file write-port merger: the execute result always wins the port,
// queued load results drain when it is idle; adds forwarding and hazard flags.
module register_writeback
    import register_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]     ex_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      write,
    output logic [REG_ADDR_WIDTH-1:0] c_address,
    output logic [DATA_WIDTH-1:0]     c_in,
    input  logic [REG_ADDR_WIDTH-1:0] a_address,
    input  logic [REG_ADDR_WIDTH-1:0] b_address,
    output logic                      fwd_a_hit,
    output logic [DATA_WIDTH-1:0]     fwd_a_data,
    output logic                      fwd_b_hit,
    output logic [DATA_WIDTH-1:0]     fwd_b_data,
    input  logic [REG_ADDR_WIDTH-1:0] hz_address,
    output logic                      hz_pending,
    output logic                      busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                                 fifo_push;
    logic                                 fifo_pop;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic [CW-1:0]                        fifo_count;
    logic [REG_ADDR_WIDTH-1:0]            head_rd;
    logic [DATA_WIDTH-1:0]                head_data;
    logic [DEPTH-1:0]                     valid_vec;
    logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_vec;
    logic                                 ex_take;
    logic                                 hz_match;

    // Load handshake: a transfer happens on any cycle with mem_valid && mem_ready;
    // mem_ready reflects only the current fill level, never a same-cycle pop.
    // Transfers to r0 complete but are dropped.
    assign mem_ready = !reset && !fifo_full;
    assign fifo_push = mem_valid && mem_ready && (mem_rd != ZERO_REG);
    assign ex_take   = ex_valid && (ex_rd != ZERO_REG);
    assign fifo_pop  = !ex_take && !fifo_empty;

    wb_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_rd   (mem_rd),
        .push_data (mem_data),
        .pop       (fifo_pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .valid_vec (valid_vec),
        .rd_vec    (rd_vec)
    );

    // Address and data hold when idle so the last write stays observable.
    always_ff @(posedge clock) begin
        if (reset) begin
            write     <= 1'b0;
            c_address <= ZERO_REG;
            c_in      <= '0;
        end else if (ex_take) begin
            write     <= 1'b1;
            c_address <= ex_rd;
            c_in      <= ex_data;
        end else if (fifo_pop) begin
            write     <= 1'b1;
            c_address <= head_rd;
            c_in      <= head_data;
        end else begin
            write     <= 1'b0;
        end
    end

    always_comb begin
        fwd_a_hit  = write && (c_address != ZERO_REG) && (c_address == a_address);
        fwd_b_hit  = write && (c_address != ZERO_REG) && (c_address == b_address);
        fwd_a_data = fwd_a_hit ? c_in : '0;
        fwd_b_data = fwd_b_hit ? c_in : '0;
    end

    // The in-flight write is deliberately excluded; forwarding covers it.
    always_comb begin
        hz_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_vec[i] && (rd_vec[i] == hz_address)) begin
                hz_match = 1'b1;
            end
        end
        hz_pending = (hz_address != ZERO_REG) && hz_match;
    end

    assign busy = (fifo_count != '0) || write;

endmodule
